// File: rtl/sp_pkg.sv
// Shared definitions for the shortest-path solver and its path tracer.
// Holds the default graph size, index width, the "no predecessor" sentinel,
// and the path tracer's state encoding.
package sp_pkg;

  localparam int NUMVALS = 6;
  localparam int SIZE    = 32;
  localparam int INT_MAX = 10000;
  localparam int IDX_W   = $clog2(NUMVALS);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/sp_node_stack.sv
// LIFO of node indices used to reverse the predecessor walk.
// Ports:
//   clk, rst     clock and synchronous active-high reset (empties the stack)
//   clear        synchronous empty request
//   push, pop    push push_data / drop the top entry (push has priority)
//   push_data    node index to push
//   top          current top entry (0 when empty)
//   depth        number of stored entries, 0..DEPTH
module sp_node_stack #(
  parameter int DEPTH = sp_pkg::NUMVALS,
  parameter int W     = sp_pkg::IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] top_ptr;
  logic             full;
  logic             empty;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_ptr = cnt - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage is data only; an empty stack never exposes stale entries.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[cnt[PTR_W-1:0]] <= push_data;
    end
  end

  assign top   = empty ? '0 : mem[top_ptr[PTR_W-1:0]];
  assign depth = cnt;

endmodule

// File: rtl/sp_path_tracer.sv
// Path reconstruction back end for the shortest-path solver.
// Latches the predecessor vector and a destination, walks predecessors back
// to source node 0 while pushing each node, then streams the path
// source-first over a valid/ready interface and reports completion.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start, dst         request and destination (sampled in IDLE only)
//   p_input            predecessor vector, entry i at [i*SIZE +: SIZE]
//   busy               high whenever not IDLE
//   out_valid/out_node/out_last/out_ready   path stream, source first
//   done, err, path_len                     one-cycle completion report
module sp_path_tracer #(
  parameter int NUMVALS = sp_pkg::NUMVALS,
  parameter int SIZE    = sp_pkg::SIZE,
  parameter int INT_MAX = sp_pkg::INT_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SIZE-1:0]         dst,
  input  logic [NUMVALS*SIZE-1:0] p_input,
  output logic                    busy,
  output logic                    out_valid,
  output logic [SIZE-1:0]         out_node,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    done,
  output logic                    err,
  output logic [SIZE-1:0]         path_len
);

  import sp_pkg::*;

  localparam int NODE_W = $clog2(NUMVALS);
  localparam int CNT_W  = $clog2(NUMVALS+1);

  state_t            state, state_nxt;
  logic [SIZE-1:0]   pv [NUMVALS];
  logic [SIZE-1:0]   cur, cur_nxt;
  logic [SIZE-1:0]   pred;
  logic [SIZE-1:0]   len_q;
  logic              err_q, err_set;
  logic              push, pop, clear;
  logic              cur_oob, pred_bad, accept;
  logic [NODE_W-1:0] top;
  logic [CNT_W-1:0]  depth;

  sp_node_stack #(
    .DEPTH (NUMVALS),
    .W     (NODE_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (cur[NODE_W-1:0]),
    .top       (top),
    .depth     (depth)
  );

  // Range checks are done on the full-width value before any truncation.
  // pred is only consulted when cur is in range, so the truncated index
  // never selects a nonexistent entry in a way that matters.
  assign cur_oob  = (cur >= SIZE'(NUMVALS));
  assign pred     = pv[cur[NODE_W-1:0]];
  assign pred_bad = (pred == SIZE'(INT_MAX)) || (pred >= SIZE'(NUMVALS));
  assign accept   = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          cur_nxt   = dst;
          state_nxt = WALK;
        end
      end
      WALK: begin
        // A full stack with the walk still going means the predecessors
        // contain a cycle.
        if (cur_oob || (depth == CNT_W'(NUMVALS))) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end else begin
          push = 1'b1;
          if (cur == '0) begin
            state_nxt = EMIT;
          end else if (pred_bad) begin
            err_set   = 1'b1;
            state_nxt = DONE;
          end else begin
            cur_nxt = pred;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pop = 1'b1;
          if (depth == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        err_q <= 1'b0;
        len_q <= '0;
      end else begin
        if (err_set) begin
          err_q <= 1'b1;
        end
        if (push) begin
          len_q <= len_q + SIZE'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    cur <= cur_nxt;
    if (accept) begin
      for (int i = 0; i < NUMVALS; i++) begin
        pv[i] <= p_input[i*SIZE +: SIZE];
      end
    end
  end

  // Every output is decoded from registered state only; out_ready never
  // reaches an output combinationally.
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign out_node  = out_valid ? SIZE'(top) : '0;
  assign out_last  = out_valid && (depth == CNT_W'(1));
  assign done      = (state == DONE);
  assign err       = done && err_q;
  assign path_len  = (done && !err_q) ? len_q : '0;

endmodule

// File: tb/tb_sp_path_tracer.sv
// Directed, table-driven bench for sp_path_tracer.
module tb_sp_path_tracer;

  localparam int NUMVALS = 6;
  localparam int SIZE    = 32;
  localparam int INT_MAX = 10000;
  localparam int IM      = INT_MAX;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [SIZE-1:0]         dst;
  logic [NUMVALS*SIZE-1:0] p_input;
  logic                    busy;
  logic                    out_valid;
  logic [SIZE-1:0]         out_node;
  logic                    out_last;
  logic                    out_ready;
  logic                    done;
  logic                    err;
  logic [SIZE-1:0]         path_len;

  sp_path_tracer #(
    .NUMVALS (NUMVALS),
    .SIZE    (SIZE),
    .INT_MAX (INT_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dst       (dst),
    .p_input   (p_input),
    .busy      (busy),
    .out_valid (out_valid),
    .out_node  (out_node),
    .out_last  (out_last),
    .out_ready (out_ready),
    .done      (done),
    .err       (err),
    .path_len  (path_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [31:0] dst;
    int          pvsel;
    int          n;
    int          nodes[6];
    int          first_cyc;
    int          done_cyc;
    bit          exp_err;
    int          plen;
    int          lo_s;
    int          lo_e;
    bit          stray;
  } vec_t;

  logic [NUMVALS*SIZE-1:0] pv_tab[3];
  vec_t                    vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUMVALS*SIZE-1:0] pack6(input int a0, input int a1, input int a2,
                                                     input int a3, input int a4, input int a5);
    logic [NUMVALS*SIZE-1:0] r;
    r[0*SIZE +: SIZE] = SIZE'(a0);
    r[1*SIZE +: SIZE] = SIZE'(a1);
    r[2*SIZE +: SIZE] = SIZE'(a2);
    r[3*SIZE +: SIZE] = SIZE'(a3);
    r[4*SIZE +: SIZE] = SIZE'(a4);
    r[5*SIZE +: SIZE] = SIZE'(a5);
    return r;
  endfunction

  // Start at cycle 0, then observe cycles 1.. until done; cycle numbers
  // are relative to the start cycle.
  task automatic run(input vec_t v);
    int          first, k, dcyc, bad_last;
    logic [31:0] derr, dlen, hold_node;
    logic        hold, hold_last;
    int          got_nodes[6];
    logic        got_last[6];
    p_input   = pv_tab[v.pvsel];
    dst       = v.dst;
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    chk({v.name, "_busy1"}, 32'(busy), 32'd1);
    first = -1; k = 0; dcyc = -1; bad_last = 0; hold = 1'b0;
    hold_node = '0; hold_last = 1'b0; derr = '0; dlen = '0;
    for (int i = 0; i < 6; i++) begin
      got_nodes[i] = -1;
      got_last[i]  = 1'b0;
    end
    for (int c = 1; c <= 60; c++) begin
      out_ready = !(c >= v.lo_s && c <= v.lo_e);
      if (v.stray && c == 2) begin
        start = 1'b1;
        dst   = '0;
      end else begin
        start = 1'b0;
      end
      if (hold) begin
        chk({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, "_hold_node"}, out_node, hold_node);
        chk({v.name, "_hold_last"}, 32'(out_last), 32'(hold_last));
      end
      hold = 1'b0;
      if (out_last && !out_valid) bad_last++;
      if (out_valid) begin
        if (first < 0) first = c;
        if (out_ready) begin
          if (k < 6) begin
            got_nodes[k] = int'(out_node);
            got_last[k]  = out_last;
          end
          k++;
        end else begin
          hold      = 1'b1;
          hold_node = out_node;
          hold_last = out_last;
        end
      end
      if (done) begin
        dcyc = c;
        derr = 32'(err);
        dlen = path_len;
        break;
      end
      step();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (dcyc < 0) chk({v.name, "_timeout"}, 32'd0, 32'd1);
    chk({v.name, "_first_valid_cyc"}, 32'(first), 32'(v.first_cyc));
    chk({v.name, "_emitted"}, 32'(k), 32'(v.n));
    for (int i = 0; i < v.n && i < 6; i++) begin
      chk($sformatf("%s_node%0d", v.name, i), 32'(got_nodes[i]), 32'(v.nodes[i]));
      chk($sformatf("%s_last%0d", v.name, i), 32'(got_last[i]), 32'(i == v.n - 1));
    end
    chk({v.name, "_last_without_valid"}, 32'(bad_last), 32'd0);
    chk({v.name, "_done_cyc"}, 32'(dcyc), 32'(v.done_cyc));
    chk({v.name, "_err"}, derr, 32'(v.exp_err));
    chk({v.name, "_path_len"}, dlen, 32'(v.plen));
    step();
    chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({v.name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dst = '0; p_input = '0; out_ready = 1'b0;

    pv_tab[0] = pack6(IM, 0, 1, 1, 2, IM);
    pv_tab[1] = pack6(IM, 0, 3, 2, 2, IM);
    pv_tab[2] = pack6(IM, 0, 1, 1, 9, IM);

    //          name       dst            pv n  nodes               first done err len lo_s lo_e stray
    vecs[0] = '{"dst4",    32'd4,         0, 4, '{0, 1, 2, 4, 0, 0},  5,  9, 1'b0, 4, 0, -1, 1'b1};
    vecs[1] = '{"dst0",    32'd0,         0, 1, '{0, 0, 0, 0, 0, 0},  2,  3, 1'b0, 1, 0, -1, 1'b0};
    vecs[2] = '{"dst5",    32'd5,         0, 0, '{0, 0, 0, 0, 0, 0}, -1,  2, 1'b1, 0, 0, -1, 1'b0};
    vecs[3] = '{"dst7",    32'd7,         0, 0, '{0, 0, 0, 0, 0, 0}, -1,  2, 1'b1, 0, 0, -1, 1'b0};
    vecs[4] = '{"dst6",    32'd6,         0, 0, '{0, 0, 0, 0, 0, 0}, -1,  2, 1'b1, 0, 0, -1, 1'b0};
    vecs[5] = '{"dsthuge", 32'h8000_0000, 0, 0, '{0, 0, 0, 0, 0, 0}, -1,  2, 1'b1, 0, 0, -1, 1'b0};
    vecs[6] = '{"cycle",   32'd2,         1, 0, '{0, 0, 0, 0, 0, 0}, -1,  8, 1'b1, 0, 0, -1, 1'b0};
    vecs[7] = '{"predoob", 32'd4,         2, 0, '{0, 0, 0, 0, 0, 0}, -1,  2, 1'b1, 0, 0, -1, 1'b0};
    vecs[8] = '{"dst1",    32'd1,         0, 2, '{0, 1, 0, 0, 0, 0},  3,  5, 1'b0, 2, 0, -1, 1'b0};
    vecs[9] = '{"bp",      32'd4,         0, 4, '{0, 1, 2, 4, 0, 0},  5, 12, 1'b0, 4, 6,  8, 1'b0};

    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_node", out_node, 32'd0);
    chk("rst_len", path_len, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run(vecs[i]);

    // Reset in the middle of emission abandons the path.
    p_input   = pv_tab[0];
    dst       = 32'd4;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    chk("mid_valid6", 32'(out_valid), 32'd1);
    chk("mid_node6", out_node, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_node", out_node, 32'd0);
    chk("mid_rst_len", path_len, 32'd0);
    rst = 1'b0;
    run('{"after_rst", 32'd3, 0, 3, '{0, 1, 3, 0, 0, 0}, 4, 7, 1'b0, 3, 0, -1, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sp_path_tracer.md
# sp_path_tracer

Sequential path-reconstruction back end for the shortest-path solver. It latches the solver's predecessor vector and a destination node, then walks predecessors back to source node 0. The walk is pushed onto an internal LIFO, and the path is streamed out source-first over a valid/ready interface. It sits between the combinational solver output and any consumer of node-by-node routes.

## Interface
- NUMVALS, 6, number of graph nodes; source is node 0
- SIZE, 32, width of a node index and of each predecessor entry
- INT_MAX, 10000, "no predecessor" sentinel written by the solver
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only in IDLE
- dst  input  SIZE  destination node; sampled with start
- p_input  input  NUMVALS*SIZE  predecessor vector; entry i at [i*SIZE +: SIZE]; sampled with start
- busy  output  1  high in every state except IDLE
- out_valid  output  1  path node available
- out_node  output  SIZE  current path node, source-first
- out_last  output  1  qualifies out_valid; final node (= dst)
- out_ready  input  1  consumer accepts out_node
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; path invalid, nothing emitted
- path_len  output  SIZE  valid with done; node count, or 0 on err

## Operation
- States: IDLE, WALK, EMIT, DONE.
- IDLE, start=1:
  - register p_input into pv[] and dst into cur;
  - clear stack and err flag;
  - go to WALK.
- IDLE, start=0: stay in IDLE.
- WALK: one step per cycle, checks in this order:
  - cur ≥ NUMVALS, or stack depth == NUMVALS (cycle in predecessors) → set err; go to DONE; no push;
  - otherwise push cur;
  - cur == 0 → go to EMIT;
  - pv[cur] == INT_MAX or pv[cur] ≥ NUMVALS → set err; go to DONE;
  - otherwise cur ← pv[cur].
- EMIT:
  - out_valid=1; out_node = stack top; out_last=1 when depth==1;
  - on out_valid&&out_ready, pop;
  - pop of last entry → go to DONE.
- DONE, one cycle:
  - done=1; err = error flag;
  - path_len = pushed count, or 0 if err;
  - go to IDLE.
- start outside IDLE is ignored; there is no queueing.
- Comparisons are unsigned at SIZE bits. Node indices are truncated to $clog2(NUMVALS) bits only after the range check.
- Reset in any state:
  - state=IDLE; stack cleared;
  - busy, out_valid, out_last, done, err = 0; out_node = 0; path_len = 0.
  - An in-flight path is abandoned and not resumed.

## Timing
- start at cycle 0 → busy from cycle 1. A path of L nodes occupies WALK cycles 1..L.
- First out_valid at cycle L+1. With out_ready held high, one node per cycle, last node at cycle 2L, done at cycle 2L+1, IDLE (busy=0) at cycle 2L+2.
- Error detected in WALK cycle k → done/err at cycle k+1.
- Backpressure: out_node and out_last are held stable while out_valid && !out_ready. out_valid never drops before acceptance.
- out_ready is a don't-care outside EMIT. Output ports are registered, with no combinational path from out_ready to out_valid.
- A new start is accepted no earlier than the cycle after DONE.

## Structure
- Package sp_pkg holds:
  - defaults NUMVALS/SIZE/INT_MAX (shared with the solver);
  - IDX_W = $clog2(NUMVALS);
  - state enum {IDLE, WALK, EMIT, DONE}.
- Sub-module sp_node_stack: LIFO of depth NUMVALS and width IDX_W, with push, pop, clear, top, and depth ($clog2(NUMVALS+1) bits). Synchronous clear on rst.
- The top level holds the FSM, the pv[] register file, cur, and the error flag.

## Test plan
- pv=[INT_MAX,0,1,1,2,INT_MAX], dst=4, ready=1, start at cycle 0 → nodes 0,1,2,4 at cycles 5–8; out_last only at cycle 8; done at 9, err=0, path_len=4.
- Same pv, dst=0 → single node 0 at cycle 2 with out_last=1; done at 3, path_len=1.
- Same pv, dst=5 → no out_valid; done at cycle 2 with err=1, path_len=0. dst=7 → done at cycle 2, err=1.
- pv[2]=3, pv[3]=2, dst=2 → depth limit reached in cycle 7; done at 8, err=1, no emission.
- dst=4 case with out_ready low for cycles 6–8 → node 1 held stable at cycles 6–9, then 2 at 10 and 4 at 11; done at 12.
- Reset asserted at cycle 6 of the dst=4 case → cycle 7: all outputs 0, IDLE. Fresh start with dst=3 → path 0,1,3 completes correctly.
